// File: rtl/ppc_types.sv
// ppc_types: shared player state encoding and default instruction width.
package ppc_types;
    localparam int PPC_INSTR_WIDTH = 32;
    typedef enum logic {IDLE, PLAY} player_state_t;
endpackage

// File: rtl/ppc_instr_player_if.sv
// ppc_instr_player_if: instruction stream handshake between player and core.
// Ports: instruction_valid/instruction driven by the player (master),
//        instruction_ready driven by the consuming core (slave).
interface ppc_instr_player_if #(parameter int INSTR_WIDTH = 32);
    logic                   instruction_valid;
    logic                   instruction_ready;
    logic [0:INSTR_WIDTH-1] instruction;
    modport master (output instruction_valid, output instruction, input instruction_ready);
    modport slave  (input instruction_valid, input instruction, output instruction_ready);
endinterface

// File: rtl/ppc_instr_mem.sv
// ppc_instr_mem: DEPTH x WIDTH program store, one sync write port, one async read port.
// Ports: clk, we/waddr/wdata (write at rising edge), raddr/rdata (combinational read).
module ppc_instr_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ppc_instr_player.sv
// ppc_instr_player: plays a loaded instruction program out over a valid/ready stream.
// Ports: clk, rst (sync, active-low); load_valid/load_addr/load_data write program
//        memory while idle; length/loop_mode sampled at start; start/stop control;
//        bus (master) carries instruction_valid/instruction/instruction_ready;
//        busy, done (one-cycle pulse at playback end), issued_count (handshakes).
module ppc_instr_player import ppc_types::*; #(
    parameter int DEPTH = 16,
    parameter int INSTR_WIDTH = PPC_INSTR_WIDTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    input  logic [AW-1:0]          load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic [AW:0]            length,
    input  logic                   loop_mode,
    input  logic                   start,
    input  logic                   stop,
    ppc_instr_player_if.master     bus,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            issued_count
);
    player_state_t          state;
    logic [AW-1:0]          ptr;
    logic [AW:0]            len_q;
    logic                   loop_q;
    logic                   stop_pend;
    logic [INSTR_WIDTH-1:0] rd_data;
    logic [AW-1:0]          nxt;
    logic                   hs;
    logic                   last;
    logic                   end_pass;

    assign hs       = bus.instruction_valid && bus.instruction_ready;
    assign last     = {1'b0, ptr} == len_q - 1'b1;
    assign nxt      = last ? '0 : ptr + 1'b1;
    assign end_pass = stop || stop_pend || (last && !loop_q);
    assign busy     = state == PLAY;

    // Read address looks one word ahead so the next word can be registered
    // at the handshake edge; in IDLE it points at entry 0 for the start edge.
    ppc_instr_mem #(.DEPTH(DEPTH), .WIDTH(INSTR_WIDTH)) u_mem (
        .clk   (clk),
        .we    (load_valid && state == IDLE && !start),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (state == IDLE ? '0 : nxt),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                 <= IDLE;
            bus.instruction_valid <= 1'b0;
            bus.instruction       <= '0;
            done                  <= 1'b0;
            issued_count          <= '0;
            stop_pend             <= 1'b0;
            ptr                   <= '0;
            len_q                 <= '0;
            loop_q                <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    issued_count <= '0;
                    stop_pend    <= 1'b0;
                    ptr          <= '0;
                    len_q        <= length;
                    loop_q       <= loop_mode;
                    if (length != '0) begin
                        state                 <= PLAY;
                        bus.instruction_valid <= 1'b1;
                        bus.instruction       <= rd_data;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end else if (hs) begin
                issued_count <= issued_count + 32'd1;
                if (end_pass) begin
                    state                 <= IDLE;
                    bus.instruction_valid <= 1'b0;
                    bus.instruction       <= '0;
                    done                  <= 1'b1;
                    stop_pend             <= 1'b0;
                end else begin
                    ptr             <= nxt;
                    bus.instruction <= rd_data;
                end
            end else if (stop) begin
                stop_pend <= 1'b1;
            end
        end
    end
endmodule
